// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for mem_port_arbiter: FSM state encoding and default timeout.
package mem_port_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    localparam int unsigned MAX_WAIT_DEFAULT = 15;

endpackage

// File: rtl/mem_port_arbiter_mux.sv
// Two-input 32-bit selector used for the shared memory address and write-data paths.
module mux64_32 (
    input  logic [31:0] i_d0,
    input  logic [31:0] i_d1,
    input  logic        i_s,
    output logic [31:0] o_y
);

    assign o_y = i_s ? i_d1 : i_d0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single memory port, with a wait-cycle timeout.
// Define ARB_ROUND_ROBIN_EN for round-robin; otherwise B has fixed priority over A.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_ack,
    output logic        a_err,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_ack,
    output logic        b_err,
    output logic [31:0] b_rdata,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        grant_b,
    output logic        busy
);

    // The final ACCESS cycle is the one where the counter still reads MAX_WAIT-1,
    // so ack/err become visible exactly MAX_WAIT cycles after mem_valid rises.
    localparam logic [7:0] LP_WAIT_LAST = 8'(MAX_WAIT - 1);

    arb_state_t  r_state;
    arb_state_t  w_next_state;
    logic        r_grant_b;
    logic [7:0]  r_wait;
    logic        r_a_ack;
    logic        r_a_err;
    logic        r_b_ack;
    logic        r_b_err;
    logic [31:0] r_a_rdata;
    logic [31:0] r_b_rdata;
    logic        w_win_b;
    logic        w_start;
    logic        w_done_ok;
    logic        w_done_to;
    logic        w_access;

`ifdef ARB_ROUND_ROBIN_EN
    logic        r_rr_b;

    assign w_win_b = b_req & (~a_req | r_rr_b);
`else
    assign w_win_b = b_req;
`endif

    assign w_access = (r_state == ACCESS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_done_ok    = 1'b0;
        w_done_to    = 1'b0;
        case (r_state)
            IDLE: begin
                if (a_req || b_req) begin
                    w_start      = 1'b1;
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    w_done_ok    = 1'b1;
                    w_next_state = IDLE;
                end else if (r_wait == LP_WAIT_LAST) begin
                    w_done_to    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_b <= 1'b0;
            r_wait    <= '0;
            r_a_ack   <= 1'b0;
            r_a_err   <= 1'b0;
            r_b_ack   <= 1'b0;
            r_b_err   <= 1'b0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_rr_b    <= 1'b0;
`endif
        end else begin
            r_a_ack <= 1'b0;
            r_a_err <= 1'b0;
            r_b_ack <= 1'b0;
            r_b_err <= 1'b0;
            if (w_start) begin
                r_grant_b <= w_win_b;
                r_wait    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                r_rr_b    <= ~w_win_b;
`endif
            end else if (w_access && !mem_ready) begin
                r_wait <= r_wait + 8'd1;
            end
            if (w_done_ok) begin
                if (r_grant_b) begin
                    r_b_ack   <= 1'b1;
                    r_b_rdata <= mem_rdata;
                end else begin
                    r_a_ack   <= 1'b1;
                    r_a_rdata <= mem_rdata;
                end
            end
            if (w_done_to) begin
                if (r_grant_b) begin
                    r_b_ack <= 1'b1;
                    r_b_err <= 1'b1;
                end else begin
                    r_a_ack <= 1'b1;
                    r_a_err <= 1'b1;
                end
            end
        end
    end

    mux64_32 u_addr_mux (
        .i_d0 (a_addr),
        .i_d1 (b_addr),
        .i_s  (r_grant_b),
        .o_y  (mem_addr)
    );

    mux64_32 u_wdata_mux (
        .i_d0 (a_wdata),
        .i_d1 (b_wdata),
        .i_s  (r_grant_b),
        .o_y  (mem_wdata)
    );

    assign mem_valid = w_access;
    assign busy      = w_access;
    assign mem_we    = w_access & (r_grant_b ? b_we : a_we);
    assign grant_b   = r_grant_b;
    assign a_ack     = r_a_ack;
    assign a_err     = r_a_err;
    assign a_rdata   = r_a_rdata;
    assign b_ack     = r_b_ack;
    assign b_err     = r_b_err;
    assign b_rdata   = r_b_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int unsigned MW = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [31:0] a_addr = '0, a_wdata = '0;
    logic        a_ack, a_err;
    logic [31:0] a_rdata;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [31:0] b_addr = '0, b_wdata = '0;
    logic        b_ack, b_err;
    logic [31:0] b_rdata;
    logic        mem_valid, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        grant_b, busy;

    int          n_err = 0;
    int          n_chk = 0;

    // Model: round-robin preference and last completed read data per requester.
    bit          m_rr_b = 1'b0;
    logic [31:0] m_a_rdata = '0;
    logic [31:0] m_b_rdata = '0;

    mem_port_arbiter #(.MAX_WAIT(MW)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_ack     (a_ack),
        .a_err     (a_err),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_ack     (b_ack),
        .b_err     (b_err),
        .b_rdata   (b_rdata),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .grant_b   (grant_b),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_valid"}, {31'b0, mem_valid}, 32'd0);
        check_val({tag, "_we"},    {31'b0, mem_we},    32'd0);
        check_val({tag, "_busy"},  {31'b0, busy},      32'd0);
        check_val({tag, "_acks"},  {28'b0, a_ack, a_err, b_ack, b_err}, 32'd0);
        check_val({tag, "_ardata"}, a_rdata, m_a_rdata);
        check_val({tag, "_brdata"}, b_rdata, m_b_rdata);
    endtask

    // Requests are already presented to an idle DUT; this covers grant through ack.
    // Memory answers in access cycle lat-1 (counting from 0) unless that is past the timeout.
    task automatic serve(input bit ra, input bit rb, input int unsigned lat,
                         input bit drop, input logic [31:0] data);
        bit          wb;
        bit          to;
        int unsigned ncyc;
        logic [31:0] e_addr, e_wd;
        logic        e_we;
`ifdef ARB_ROUND_ROBIN_EN
        wb     = rb && (!ra || m_rr_b);
        m_rr_b = !wb;
`else
        wb     = rb;
`endif
        e_addr = wb ? b_addr : a_addr;
        e_wd   = wb ? b_wdata : a_wdata;
        e_we   = wb ? b_we : a_we;
        to     = (lat > MW);
        ncyc   = to ? MW : lat;
        for (int unsigned k = 0; k < ncyc; k++) begin
            @(negedge clk);
            check_val("acc_valid", {31'b0, mem_valid}, 32'd1);
            check_val("acc_busy",  {31'b0, busy},      32'd1);
            check_val("acc_grant", {31'b0, grant_b},   {31'b0, wb});
            check_val("acc_addr",  mem_addr,  e_addr);
            check_val("acc_wdata", mem_wdata, e_wd);
            check_val("acc_we",    {31'b0, mem_we}, {31'b0, e_we});
            check_val("acc_noack", {28'b0, a_ack, a_err, b_ack, b_err}, 32'd0);
            if (drop && k == 0) begin
                a_req = 1'b0;
                b_req = 1'b0;
            end
            mem_ready = (k == lat - 1);
            mem_rdata = data;
        end
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        if (!to) begin
            if (wb) m_b_rdata = data;
            else    m_a_rdata = data;
        end
        check_val("done_a", {30'b0, a_ack, a_err}, wb ? 32'd0 : {30'b0, 1'b1, to});
        check_val("done_b", {30'b0, b_ack, b_err}, wb ? {30'b0, 1'b1, to} : 32'd0);
        check_val("done_ardata", a_rdata, m_a_rdata);
        check_val("done_brdata", b_rdata, m_b_rdata);
        check_val("done_valid", {31'b0, mem_valid}, 32'd0);
        a_req = 1'b0;
        b_req = 1'b0;
        @(negedge clk);
        check_quiet("after");
    endtask

    task automatic run_txn(input bit ra, input bit rb, input int unsigned lat,
                           input bit drop, input logic [31:0] data);
        @(negedge clk);
        check_quiet("idle");
        a_req     = ra;
        b_req     = rb;
        mem_ready = 1'b0;
        serve(ra, rb, lat, drop, data);
    endtask

    task automatic idle_ready;
        @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = $urandom;
        @(negedge clk);
        mem_ready = 1'b0;
        check_quiet("idle_rdy");
    endtask

    task automatic randomize_ports;
        a_addr  = $urandom;
        a_wdata = $urandom;
        a_we    = 1'($urandom_range(0, 1));
        b_addr  = $urandom;
        b_wdata = $urandom;
        b_we    = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned r;
        bit          ra, rb;

        #12;
        check_quiet("reset");
        check_val("reset_grant", {31'b0, grant_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Simultaneous reads straight after reset expose the arbitration order.
        a_we = 1'b0;
        b_we = 1'b0;
        for (int i = 0; i < 3; i++) run_txn(1'b1, 1'b1, 2, 1'b0, 32'd30);

        // Single A write with a two-cycle memory.
        a_addr  = 32'h100;
        a_wdata = 32'd40;
        a_we    = 1'b1;
        run_txn(1'b1, 1'b0, 2, 1'b0, 32'h5a5a_0001);

        // B read that the memory never answers, then one answered on the last legal cycle.
        b_we = 1'b0;
        run_txn(1'b0, 1'b1, MW + 10, 1'b0, 32'hdead_beef);
        run_txn(1'b0, 1'b1, MW, 1'b0, 32'hcafe_0032);
        run_txn(1'b1, 1'b0, 1, 1'b0, 32'h0000_1111);

        // Request withdrawn right after the grant.
        run_txn(1'b1, 1'b0, 4, 1'b1, 32'h0bad_f00d);
        run_txn(1'b0, 1'b1, 3, 1'b1, 32'h1234_5678);

        idle_ready();
        idle_ready();

        // Reset asserted in access cycle 1 with both requests still held.
        @(negedge clk);
        a_req = 1'b1;
        b_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_rr_b    = 1'b0;
        m_a_rdata = '0;
        m_b_rdata = '0;
        check_quiet("rst_mid");
        check_val("rst_mid_grant", {31'b0, grant_b}, 32'd0);
        @(negedge clk);
        check_quiet("rst_hold");
        rst_n = 1'b1;
        serve(1'b1, 1'b1, 3, 1'b0, 32'h7777_0033);

        for (int i = 0; i < 40; i++) begin
            randomize_ports();
            r  = $urandom_range(1, 3);
            ra = r[0];
            rb = r[1];
            if ($urandom_range(0, 5) == 0) idle_ready();
            run_txn(ra, rb, $urandom_range(1, MW + 3), ($urandom_range(0, 3) == 0), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
